// File: rtl/ts4231_pkg.sv
// Shared types and helpers for the TS4231 configuration scheduler.
package ts4231_pkg;

    typedef enum logic [2:0] {PWRUP, PICK, START, WAIT, GAP, IDLE} state_e;

    function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned cyc_per_us);
        return us * cyc_per_us;
    endfunction

    // Channel select width; a single-bit select is kept even for tiny channel counts.
    function automatic int sel_w(input int n_ch);
        int w;
        w = $clog2(n_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ts4231_cfg_scheduler_if.sv
// Engine handshake and channel status bundle between the scheduler and its surroundings.
interface ts4231_cfg_scheduler_if #(
    parameter int N_CH = 4,
    parameter int SELW = 2
);
    logic [N_CH-1:0] rescan_req;
    logic            eng_done;
    logic            eng_ok;
    logic            eng_start;
    logic [SELW-1:0] eng_sel;
    logic            busy;
    logic [N_CH-1:0] chan_ok;
    logic [N_CH-1:0] chan_fail;
    logic            scan_done;

    modport master (
        input  rescan_req, eng_done, eng_ok,
        output eng_start, eng_sel, busy, chan_ok, chan_fail, scan_done
    );

    modport slave (
        output rescan_req, eng_done, eng_ok,
        input  eng_start, eng_sel, busy, chan_ok, chan_fail, scan_done
    );
endinterface

// File: rtl/ts4231_prio_pick.sv
// Combinational lowest-set-bit encoder: idx is the lowest requesting channel, any flags a request.
module ts4231_prio_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ts4231_cfg_scheduler.sv
// Time-shares one TS4231 configuration engine across N_CH sensor channels with
// power-up delay, per-attempt timeout, bounded retries and per-channel rescan.
module ts4231_cfg_scheduler
    import ts4231_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 48_000_000,
    parameter int          N_CH        = 4,
    parameter int unsigned POWERUP_US  = 10_000,
    parameter int unsigned TIMEOUT_US  = 50_000,
    parameter int          MAX_RETRY   = 3
) (
    input logic                    clk,
    input logic                    reset,
    ts4231_cfg_scheduler_if.master bus
);
    localparam int          SELW        = sel_w(N_CH);
    localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned POWERUP_CYC = us_to_cyc(POWERUP_US, CYC_PER_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cyc(TIMEOUT_US, CYC_PER_US);
    localparam logic [31:0] PWR_LAST    = (POWERUP_CYC > 0) ? 32'(POWERUP_CYC - 1) : 32'd0;
    localparam logic [31:0] TMO_LAST    = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0] RETRY_LIM   = 32'(MAX_RETRY);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    state_e          state_q;
    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] ok_q;
    logic [N_CH-1:0] fail_q;
    logic [SELW-1:0] sel_q;
    logic [31:0]     pwr_cnt_q;
    logic [31:0]     tmo_cnt_q;
    logic [31:0]     retry_q;
    logic            start_q;
    logic            busy_q;
    logic            scan_q;
    logic            again_q;

    logic [SELW-1:0] pick_idx;
    logic            pick_any;
    logic            tmo_hit;
    logic            attempt_end;
    logic            attempt_bad;
    logic [31:0]     retry_inc;
    logic            retry_left;

    ts4231_prio_pick #(.N(N_CH), .W(SELW)) u_pick (
        .req (pending_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A done in the timeout cycle takes precedence, so its eng_ok decides the outcome.
    assign tmo_hit     = (tmo_cnt_q >= TMO_LAST);
    assign attempt_end = bus.eng_done | tmo_hit;
    assign attempt_bad = bus.eng_done ? ~bus.eng_ok : 1'b1;
    assign retry_inc   = sat_inc(retry_q);
    assign retry_left  = (retry_inc < RETRY_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PWRUP;
            pending_q <= '1;
            ok_q      <= '0;
            fail_q    <= '0;
            sel_q     <= '0;
            pwr_cnt_q <= '0;
            tmo_cnt_q <= '0;
            retry_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b1;
            scan_q    <= 1'b0;
            again_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            scan_q  <= 1'b0;
            case (state_q)
                PWRUP: begin
                    if (pwr_cnt_q >= PWR_LAST) state_q <= PICK;
                    else                       pwr_cnt_q <= sat_inc(pwr_cnt_q);
                end
                PICK: begin
                    if (pick_any) begin
                        sel_q   <= pick_idx;
                        start_q <= 1'b1;
                        state_q <= START;
                    end else begin
                        scan_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                START: begin
                    // Counts cycles elapsed since eng_start rose.
                    tmo_cnt_q <= 32'd1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (attempt_end) begin
                        state_q <= GAP;
                        if (!attempt_bad) begin
                            ok_q[sel_q]      <= 1'b1;
                            fail_q[sel_q]    <= 1'b0;
                            pending_q[sel_q] <= 1'b0;
                            retry_q          <= '0;
                            again_q          <= 1'b0;
                        end else if (retry_left) begin
                            retry_q <= retry_inc;
                            again_q <= 1'b1;
                        end else begin
                            fail_q[sel_q]    <= 1'b1;
                            pending_q[sel_q] <= 1'b0;
                            retry_q          <= '0;
                            again_q          <= 1'b0;
                        end
                    end else begin
                        tmo_cnt_q <= sat_inc(tmo_cnt_q);
                    end
                end
                GAP: begin
                    if (again_q) begin
                        start_q <= 1'b1;
                        state_q <= START;
                    end else begin
                        state_q <= PICK;
                    end
                end
                IDLE: begin
                    if (|pending_q) begin
                        busy_q  <= 1'b1;
                        state_q <= PICK;
                    end
                end
                default: state_q <= PWRUP;
            endcase
            // Rescan overrides any completion landing in the same cycle.
            for (int i = 0; i < N_CH; i++) begin
                if (bus.rescan_req[i]) begin
                    pending_q[i] <= 1'b1;
                    ok_q[i]      <= 1'b0;
                    fail_q[i]    <= 1'b0;
                end
            end
        end
    end

    assign bus.eng_start = start_q;
    assign bus.eng_sel   = sel_q;
    assign bus.busy      = busy_q;
    assign bus.chan_ok   = ok_q;
    assign bus.chan_fail = fail_q;
    assign bus.scan_done = scan_q;

endmodule

// File: tb/tb_ts4231_cfg_scheduler.sv
// Scoreboard bench for ts4231_cfg_scheduler: expected start/scan events are queued, a monitor pops and checks them.
module tb_ts4231_cfg_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ts4231_cfg_scheduler_if #(.N_CH(4), .SELW(2)) bus ();

    ts4231_cfg_scheduler #(
        .CLK_FREQ_HZ (1_000_000),
        .N_CH        (4),
        .POWERUP_US  (5),
        .TIMEOUT_US  (20),
        .MAX_RETRY   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] rescan_man  = 4'b0;
    logic [3:0] rescan_auto = 4'b0;
    assign bus.rescan_req = rescan_man | rescan_auto;

    int   resp_delay[4];
    logic resp_ok[4];
    logic rescan_on_done[4];

    typedef struct {
        bit         is_scan;
        int         sel;
        int         gap;
        logic [3:0] ok;
        logic [3:0] fail;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_start(input int sel, input int gap);
        exp_t e;
        e.is_scan = 1'b0; e.sel = sel; e.gap = gap; e.ok = 4'b0; e.fail = 4'b0;
        expq.push_back(e);
    endtask

    task automatic push_scan(input logic [3:0] ok, input logic [3:0] fail);
        exp_t e;
        e.is_scan = 1'b1; e.sel = 0; e.gap = -1; e.ok = ok; e.fail = fail;
        expq.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending_events"}, expq.size(), 0);
        expq.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_eng_start"}, bus.eng_start, 0);
        chk({name, "_eng_sel"},   bus.eng_sel,   0);
        chk({name, "_busy"},      bus.busy,      1);
        chk({name, "_chan_ok"},   bus.chan_ok,   0);
        chk({name, "_chan_fail"}, bus.chan_fail, 0);
        chk({name, "_scan_done"}, bus.scan_done, 0);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Engine model: answers resp_delay cycles after each start, optionally raising rescan with the done.
    initial begin : responder
        int pend = 0;
        int ch = 0;
        bus.eng_done = 1'b0;
        bus.eng_ok   = 1'b0;
        forever begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            bus.eng_ok   = 1'b0;
            rescan_auto  = 4'b0;
            if (reset) begin
                pend = 0;
            end else if (bus.eng_start) begin
                ch   = int'(bus.eng_sel);
                pend = resp_delay[ch];
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_ok   = resp_ok[ch];
                    if (rescan_on_done[ch]) begin
                        rescan_auto[ch]    = 1'b1;
                        rescan_on_done[ch] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        int last = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last = 0;
            end else begin
                if (bus.eng_start) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_start_sel", bus.eng_sel, -1);
                    end else begin
                        e = expq.pop_front();
                        chk("event_order_start", int'(e.is_scan), 0);
                        chk("start_sel", bus.eng_sel, e.sel);
                        if (e.gap >= 0) chk("start_gap", cyc - last, e.gap);
                    end
                    last = cyc;
                end
                if (bus.scan_done) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_scan_chan_ok", bus.chan_ok, -1);
                    end else begin
                        e = expq.pop_front();
                        chk("event_order_scan", int'(e.is_scan), 1);
                        chk("scan_chan_ok",   bus.chan_ok,   e.ok);
                        chk("scan_chan_fail", bus.chan_fail, e.fail);
                        chk("scan_busy",      bus.busy,      0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 4; i++) begin
            resp_delay[i]     = 2;
            resp_ok[i]        = 1'b1;
            rescan_on_done[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_reset_vals("por");

        // Full pass: every channel answers ok.
        push_start(0, 6); push_start(1, 5); push_start(2, 5); push_start(3, 5);
        push_scan(4'b1111, 4'b0000);
        reset = 1'b0;
        wait_empty("full_pass", 200);
        chk("full_pass_busy_idle", bus.busy, 0);
        chk("full_pass_chan_ok", bus.chan_ok, 4'b1111);

        // Channel 2 rejects every attempt.
        enter_reset();
        resp_ok[2] = 1'b0;
        push_start(0, 6); push_start(1, 5);
        push_start(2, 5); push_start(2, 4); push_start(2, 4);
        push_start(3, 5);
        push_scan(4'b1011, 4'b0100);
        reset = 1'b0;
        wait_empty("retry_fail", 300);

        // Channel 1 never answers: three timeouts.
        enter_reset();
        resp_ok[2]    = 1'b1;
        resp_delay[1] = 1000;
        push_start(0, 6); push_start(1, 5);
        push_start(1, 21); push_start(1, 21);
        push_start(2, 22); push_start(3, 5);
        push_scan(4'b1101, 4'b0010);
        reset = 1'b0;
        wait_empty("timeout", 400);

        // Rescan of channel 3 from IDLE.
        resp_delay[1] = 2;
        push_start(3, -1);
        push_scan(4'b1101, 4'b0010);
        @(negedge clk);
        rescan_man = 4'b1000;
        @(negedge clk);
        rescan_man = 4'b0000;
        chk("rescan_drops_ok3", bus.chan_ok, 4'b0101);
        wait_empty("rescan_idle", 100);

        // Channel 0 done coincides with rescan and with the timeout cycle.
        enter_reset();
        resp_delay[0]     = 19;
        rescan_on_done[0] = 1'b1;
        push_start(0, 6); push_start(0, 22);
        push_start(1, 22); push_start(2, 5); push_start(3, 5);
        push_scan(4'b1111, 4'b0000);
        reset = 1'b0;
        wait_empty("coincident", 400);

        // Reset while waiting on channel 1.
        enter_reset();
        resp_delay[0] = 2;
        resp_delay[1] = 1000;
        push_start(0, 6); push_start(1, 5);
        reset = 1'b0;
        wait_empty("pre_abort", 100);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_wait");
        resp_delay[1] = 2;
        push_start(0, 6); push_start(1, 5); push_start(2, 5); push_start(3, 5);
        push_scan(4'b1111, 4'b0000);
        reset = 1'b0;
        wait_empty("after_abort", 200);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ts4231_cfg_scheduler.md
Name: ts4231_cfg_scheduler

Overview:
- Sequences one shared TS4231 configuration engine across N_CH lighthouse sensor channels.
- Waits out the power-up delay, then configures each pending channel in turn: start pulse, wait for done or timeout, retry on failure.
- Publishes per-channel ok/fail status and re-queues channels on request, e.g. after a lost-lock watchdog fires.
- Sits between the sensor front-ends (E/D pin muxes) and the decoder top level.

Parameters:
- CLK_FREQ_HZ, 48_000_000, system clock frequency.
- N_CH, 4, number of sensor channels (2..16).
- POWERUP_US, 10_000, delay after reset before the first configuration.
- TIMEOUT_US, 50_000, maximum wait for eng_done per attempt.
- MAX_RETRY, 3, attempts per channel before it is marked failed (>=1).
- Derived localparams:
  - SELW = max(1, $clog2(N_CH)).
  - CYC_PER_US = CLK_FREQ_HZ/1_000_000.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- rescan_req, input, N_CH: per-channel re-configuration request; a level, sampled every cycle.
- eng_done, input, 1: one-cycle pulse from the engine when an attempt ends.
- eng_ok, input, 1: attempt result; valid only while eng_done=1.
- eng_start, output, 1: one-cycle start pulse to the engine.
- eng_sel, output, SELW: channel routed to the engine's E/D pins.
- busy, output, 1: high whenever state is not IDLE.
- chan_ok, output, N_CH: channel configured successfully.
- chan_fail, output, N_CH: channel exhausted its retries.
- scan_done, output, 1: one-cycle pulse on each entry to IDLE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - state=PWRUP; pending=all ones; all counters 0.
  - eng_start=0, eng_sel=0, busy=1, chan_ok=0, chan_fail=0, scan_done=0.
- All outputs are registered.
- Cycle counts:
  - POWERUP_CYC = POWERUP_US*CYC_PER_US.
  - TIMEOUT_CYC = TIMEOUT_US*CYC_PER_US.
  - Counters are 32 bits and saturate; they never wrap.
- States:
  - PWRUP: count up to POWERUP_CYC-1, then go to PICK. rescan_req is OR-ed into pending.
  - PICK: select the lowest-index set bit of pending. Register it to eng_sel and go to START. If pending=0, go to IDLE and pulse scan_done.
  - START: eng_start=1 for exactly one cycle. Load the timeout counter. Go to WAIT.
  - WAIT, eng_done=1 and eng_ok=1: set chan_ok[sel], clear chan_fail[sel], clear pending[sel], retry=0. Go to GAP.
  - WAIT, eng_done=1 and eng_ok=0, or timeout reached: retry+1.
    - If retry+1 < MAX_RETRY: go to GAP, then back to START.
    - Otherwise: set chan_fail[sel], clear pending[sel], retry=0, go to GAP, then to PICK.
  - GAP: one cycle with eng_sel held. Lets the pin muxes settle before reselection.
  - IDLE: any set pending bit moves to PICK on the next cycle.
- eng_sel is stable from the PICK exit until the GAP exit. It never changes during START or WAIT.
- Rescan handling:
  - A set rescan_req[i] sets pending[i] and clears chan_ok[i] and chan_fail[i] in the same cycle.
  - If it coincides with a completion that clears pending[i], the set wins. The channel is configured again; its completion flag still updates first.
- eng_done and timeout in the same cycle: eng_done wins and its eng_ok is used.
- eng_done outside WAIT: ignored.
- Reset asserted mid-operation: every register returns to its reset value next cycle and PWRUP restarts. The engine must tolerate an abandoned attempt.
- Fairness: lowest index first on each PICK. A held rescan_req can starve higher channels; this is acceptable and documented.

Decomposition:
- Shared package ts4231_pkg holds:
  - the state enum {PWRUP, PICK, START, WAIT, GAP, IDLE};
  - the us-to-cycles conversion function;
  - SELW computation.
- One sub-module, ts4231_prio_pick: combinational lowest-set-bit encoder over N_CH bits, with outputs idx and any.

Test Plan:
- Use CLK_FREQ_HZ=1_000_000, POWERUP_US=5, TIMEOUT_US=20, N_CH=4, MAX_RETRY=3 for all scenarios.
- Power-up and full pass: release reset; engine answers ok 3 cycles after each start.
  - First eng_start in cycle 6 after reset release, eng_sel=0.
  - eng_sel then steps 0,1,2,3.
  - chan_ok=4'b1111, scan_done pulses once, busy=0.
- Retry then fail: channel 2 answers ok=0 every attempt.
  - Exactly 3 starts with eng_sel=2.
  - chan_fail=4'b0100, chan_ok=4'b1011.
- Timeout: engine never answers for channel 1.
  - Restart 21 cycles after each start; 3 attempts.
  - chan_fail[1]=1, then proceeds to channel 2.
- Rescan in IDLE: pulse rescan_req=4'b1000 for one cycle.
  - chan_ok[3] drops the next cycle.
  - One start with eng_sel=3, chan_ok[3]=1 again, scan_done pulses.
- Simultaneous events: assert rescan_req[0] in the cycle channel 0's eng_done ok arrives, and in the same attempt assert eng_done together with the timeout cycle.
  - Channel 0 is configured a second time.
  - The coincident done is accepted as ok and no retry is counted.
- Reset mid-WAIT: assert reset in WAIT on channel 1.
  - All outputs return to reset values.
  - The first start comes again in cycle 6 after release, eng_sel=0.
